// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if #(
    parameter int PC_WIDTH = 20
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with a single outstanding memory request. It holds the fetched
// word and its PC until IF/ID takes it, and squashes fetches made stale by a redirect.
module if_fetch_stage #(
    parameter int                  PC_WIDTH  = 20,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 20'h00000,
    parameter logic [31:0]         NOP_INSTR = 32'h00000013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                IF_IDWrite,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    if_fetch_stage_if.master    imem,
    output logic [PC_WIDTH-1:0] IF_PC,
    output logic [31:0]         IF_Instr,
    output logic                IF_Valid,
    output logic                fetch_busy
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FULL  = 2'b10,
        ST_DROP  = 2'b11
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(3'd4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [PC_WIDTH-1:0] PC_ZERO    = {PC_WIDTH{1'b0}};

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]         buf_instr_q, buf_instr_d;
    logic                buf_valid_q, buf_valid_d;
    logic                fetch_busy_q, fetch_busy_d;
    logic                imem_req_s;
    logic [PC_WIDTH-1:0] redir_pc_s;

    assign redir_pc_s     = redirect_pc & ALIGN_MASK;
    assign imem.imem_req  = imem_req_s;
    assign imem.imem_addr = fetch_pc_q;

    // The buffer registers are kept at 0/NOP whenever empty, so they drive IF/ID directly.
    assign IF_PC      = buf_pc_q;
    assign IF_Instr   = buf_instr_q;
    assign IF_Valid   = buf_valid_q;
    assign fetch_busy = fetch_busy_q;

    // Request strobe: a new fetch may start only from an empty or draining buffer.
    always_comb begin
        imem_req_s = 1'b0;
        case (state_q)
            ST_ISSUE: imem_req_s = !redirect_valid;
            ST_FULL:  imem_req_s = IF_IDWrite && !redirect_valid;
            default:  imem_req_s = 1'b0;
        endcase
    end

    // Next-state and buffer update logic.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_valid_d = buf_valid_q;
        case (state_q)
            ST_ISSUE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc_s;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc_s;
                    if (imem.imem_rvalid) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (imem.imem_rvalid) begin
                    buf_pc_d    = fetch_pc_q;
                    buf_instr_d = imem.imem_rdata;
                    buf_valid_d = 1'b1;
                    fetch_pc_d  = fetch_pc_q + PC_STEP;
                    state_d     = ST_FULL;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FULL: begin
                if (redirect_valid || IF_IDWrite) begin
                    buf_pc_d    = PC_ZERO;
                    buf_instr_d = NOP_INSTR;
                    buf_valid_d = 1'b0;
                    if (redirect_valid) begin
                        fetch_pc_d = redir_pc_s;
                        state_d    = ST_ISSUE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (imem.imem_rvalid) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d     = ST_ISSUE;
                buf_pc_d    = PC_ZERO;
                buf_instr_d = NOP_INSTR;
                buf_valid_d = 1'b0;
            end
        endcase
        fetch_busy_d = (state_d == ST_WAIT) || (state_d == ST_DROP);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ISSUE;
            fetch_pc_q   <= RESET_PC;
            buf_pc_q     <= PC_ZERO;
            buf_instr_q  <= NOP_INSTR;
            buf_valid_q  <= 1'b0;
            fetch_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_valid_q  <= buf_valid_d;
            fetch_busy_q <= fetch_busy_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage: a variable-latency memory plus a program-flow
// reference (PC advances by 4 per delivered word, jumps on redirect) feeding a scoreboard.
module tb_if_fetch_stage;
    localparam int            PW       = 20;
    localparam logic [PW-1:0] RESET_PC = 20'h00000;
    localparam logic [31:0]   NOP      = 32'h00000013;

    typedef struct {
        logic [PW-1:0] pc;
        logic [31:0]   instr;
    } item_t;

    logic          clk            = 1'b0;
    logic          reset          = 1'b1;
    logic          IF_IDWrite     = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [PW-1:0] redirect_pc    = 20'h00000;
    logic [PW-1:0] IF_PC;
    logic [31:0]   IF_Instr;
    logic          IF_Valid;
    logic          fetch_busy;

    if_fetch_stage_if #(.PC_WIDTH(PW)) mem_bus ();

    if_fetch_stage #(.PC_WIDTH(PW), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .IF_IDWrite     (IF_IDWrite),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (mem_bus),
        .IF_PC          (IF_PC),
        .IF_Instr       (IF_Instr),
        .IF_Valid       (IF_Valid),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    item_t         exp_q[$];
    logic [PW-1:0] next_fetch = 20'h00000;
    logic [PW-1:0] req_pc     = 20'h00000;
    bit            dut_out    = 1'b0;
    bit            live       = 1'b0;
    bit            started    = 1'b0;
    // Memory model state
    bit            mem_pending = 1'b0;
    logic [PW-1:0] mem_addr    = 20'h00000;
    int            mem_cnt     = 0;
    int            lat         = 1;
    bit            spur_en     = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] word(input logic [PW-1:0] a);
        return {~a[11:0], a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs and memory response after the edge, update the model mid-cycle.
    task automatic cycle(input bit rst, input bit rv, input logic [PW-1:0] rpc, input bit wr);
        bit            req;
        logic [PW-1:0] addr;
        logic [PW-1:0] cur_fetch;
        item_t         it;
        @(posedge clk);
        #1;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        IF_IDWrite     = wr;
        mem_bus.imem_rvalid = 1'b0;
        if (mem_pending && mem_cnt == 0) begin
            mem_bus.imem_rvalid = 1'b1;
            mem_bus.imem_rdata  = word(mem_addr);
            mem_pending         = 1'b0;
        end else if (mem_pending) begin
            mem_cnt--;
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            mem_bus.imem_rvalid = 1'b1;
            mem_bus.imem_rdata  = $urandom;
        end
        @(negedge clk);
        #1;
        req       = mem_bus.imem_req;
        addr      = mem_bus.imem_addr;
        cur_fetch = next_fetch;
        if (rst) begin
            next_fetch = RESET_PC;
            dut_out    = 1'b0;
            live       = 1'b0;
            exp_q.delete();
            started    = 1'b1;
            if (mem_pending) mem_cnt = 0;
        end else begin
            if (mem_bus.imem_rvalid && dut_out) begin
                dut_out = 1'b0;
                if (live && !rv) begin
                    it.pc    = req_pc;
                    it.instr = word(req_pc);
                    exp_q.push_back(it);
                    next_fetch = req_pc + 20'h00004;
                end
            end
            if (rv) begin
                next_fetch = rpc & 20'hFFFFC;
                live       = 1'b0;
            end
            if (req) begin
                dut_out     = 1'b1;
                live        = 1'b1;
                req_pc      = cur_fetch;
                mem_pending = 1'b1;
                mem_addr    = addr;
                mem_cnt     = lat - 1;
            end
        end
    endtask

    task automatic wait_req();
        for (int n = 0; n < 12 && !dut_out; n++) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        checks++;
        if (!dut_out) begin
            errors++;
            $display("FAIL wait_req actual=idle required=request_outstanding");
        end
    endtask

    task automatic wait_full();
        for (int n = 0; n < 12 && exp_q.size() == 0; n++) cycle(1'b0, 1'b0, 20'h00000, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wait_full actual=empty required=presented");
        end
    endtask

    // Scoreboard monitor: compares DUT outputs to the expected presentation mid-cycle.
    always @(negedge clk) begin
        bit exp_req;
        if (started && !reset) begin
            exp_req = !dut_out && !redirect_valid && ((exp_q.size() == 0) || IF_IDWrite);
            check("if_valid", 32'(IF_Valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("if_pc", 32'(IF_PC), 32'(exp_q[0].pc));
                check("if_instr", IF_Instr, exp_q[0].instr);
                if (IF_IDWrite || redirect_valid) void'(exp_q.pop_front());
            end else begin
                check("if_pc_idle", 32'(IF_PC), 32'h00000000);
                check("if_instr_nop", IF_Instr, NOP);
            end
            check("imem_req", 32'(mem_bus.imem_req), 32'(exp_req));
            if (exp_req) check("imem_addr", 32'(mem_bus.imem_addr), 32'(next_fetch));
            check("fetch_busy", 32'(fetch_busy), 32'(dut_out));
        end
    end

    initial begin
        mem_bus.imem_rvalid = 1'b0;
        mem_bus.imem_rdata  = 32'h00000000;
        // Straight-line fetch with 1-cycle memory
        lat = 1;
        cycle(1'b1, 1'b0, 20'h00000, 1'b0);
        cycle(1'b1, 1'b0, 20'h00000, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        // Stall with IF_PC=0x4 presented
        cycle(1'b1, 1'b0, 20'h00000, 1'b0);
        wait_full();
        cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        wait_full();
        repeat (5) cycle(1'b0, 1'b0, 20'h00000, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        // Redirect while waiting, response arrives later
        lat = 4;
        wait_req();
        cycle(1'b0, 1'b1, 20'h00100, 1'b1);
        lat = 1;
        repeat (8) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        // Redirect coincident with the response
        lat = 2;
        wait_req();
        cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        cycle(1'b0, 1'b1, 20'h00203, 1'b1);
        lat = 1;
        repeat (6) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        // Address wrap
        cycle(1'b0, 1'b1, 20'hFFFFC, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        // Reset mid-fetch; stale response lands the cycle after reset
        lat = 3;
        wait_req();
        cycle(1'b1, 1'b0, 20'h00000, 1'b1);
        lat = 1;
        repeat (8) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        // Randomised traffic
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [PW-1:0] rpc;
            lat = $urandom_range(1, 4);
            rpc = PW'($urandom);
            if ($urandom_range(0, 3) == 0) rpc = 20'hFFFF0 | PW'($urandom_range(0, 15));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, rpc,
                  $urandom_range(0, 3) != 0);
        end
        spur_en = 1'b0;
        lat = 1;
        repeat (10) cycle(1'b0, 1'b0, 20'h00000, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time. It buffers the returned instruction together with its PC and presents the pair to IF/ID as IF_PC/IF_Instr. It honours the hazard unit's write-enable (stall) and the branch/jump redirect from later stages, and discards in-flight fetches that a redirect makes stale.

Parameters:
PC_WIDTH, 20, width of PC and instruction-memory address
RESET_PC, 20'h00000, fetch address after reset
NOP_INSTR, 32'h00000013, instruction driven when no valid instruction is presented (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
IF_IDWrite  input  1  1 = IF/ID captures this cycle; 0 = stall, hold presented instruction
redirect_valid  input  1  taken branch/jump; overrides all other activity
redirect_pc  input  PC_WIDTH  new fetch address; bits [1:0] ignored (treated as 00)
imem_req  output  1  request strobe; memory always accepts it in the same cycle
imem_addr  output  PC_WIDTH  request address, valid while imem_req=1
imem_rvalid  input  1  response valid, at least 1 cycle after the accepted request
imem_rdata  input  32  response instruction word
IF_PC  output  PC_WIDTH  PC of the presented instruction; 0 when IF_Valid=0
IF_Instr  output  32  presented instruction; NOP_INSTR when IF_Valid=0
IF_Valid  output  1  presented instruction is real
fetch_busy  output  1  a request is outstanding (state WAIT or DROP)

Behaviour:
- Registered state: fetch_pc, state {ISSUE, WAIT, FULL, DROP}, buf_pc, buf_instr, buf_valid.
- Reset (sampled at posedge, dominates everything, also mid-fetch):
  - fetch_pc=RESET_PC, state=ISSUE, buf_valid=0.
  - A response arriving after reset is ignored because state is not WAIT/DROP.
  - Outputs in the reset cycle are don't-care. From the cycle after reset: IF_Valid=0, IF_PC=0, IF_Instr=NOP_INSTR, imem_req=1, imem_addr=RESET_PC.
- imem_req is combinational:
  - 1 in ISSUE when !redirect_valid.
  - 1 in FULL when IF_IDWrite && !redirect_valid.
  - 0 otherwise.
  - imem_addr=fetch_pc.
- ISSUE:
  - redirect_valid: fetch_pc<=redirect_pc, stay ISSUE, no request.
  - Otherwise: request issued, go to WAIT.
- WAIT:
  - redirect_valid && imem_rvalid: drop the data, fetch_pc<=redirect_pc, go to ISSUE.
  - redirect_valid && !imem_rvalid: fetch_pc<=redirect_pc, go to DROP.
  - imem_rvalid: buf_pc<=fetch_pc, buf_instr<=imem_rdata, buf_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^PC_WIDTH; 0xFFFFC wraps to 0x00000), go to FULL.
  - Otherwise: stay.
- FULL (IF_Valid=1, IF_PC=buf_pc, IF_Instr=buf_instr):
  - redirect_valid: buf_valid<=0, fetch_pc<=redirect_pc, go to ISSUE. The instruction presented this cycle is killed by the external IF_IDFlush.
  - IF_IDWrite: instruction consumed at this edge, buf_valid<=0, request for fetch_pc issued this same cycle, go to WAIT.
  - Otherwise: hold all buffer contents unchanged (stall), for any number of cycles.
- DROP:
  - imem_rvalid: data discarded, go to ISSUE. If redirect_valid is also high, fetch_pc<=redirect_pc.
  - redirect_valid without imem_rvalid: fetch_pc<=redirect_pc, stay DROP.
- imem_rvalid in ISSUE or FULL is spurious and ignored; it causes no state change.
- At most one outstanding request at any time.
- Steady-state throughput with 1-cycle memory latency: one instruction per 2 cycles.
- IF_Valid=buf_valid. When IF_Valid=0, IF_PC and IF_Instr are forced to 0 and NOP_INSTR.

Test Plan:
- Reset then 1-cycle-latency memory returning addr-tagged words, IF_IDWrite=1 → requests at 0x00000, 0x00004, 0x00008 on every other cycle; IF_Valid pulses with IF_PC=0x0/0x4/0x8 and matching IF_Instr.
- Stall: IF_IDWrite=0 for 5 cycles while in FULL with IF_PC=0x00004 → IF_PC/IF_Instr constant, imem_req=0 throughout; on release, next request addr=0x00008.
- Redirect during WAIT with rvalid 3 cycles later, redirect_pc=0x00100 → state DROP, old word never presented (IF_Valid stays 0), next request addr=0x00100.
- Redirect coincident with rvalid in WAIT, redirect_pc=0x00203 → data discarded, next request addr=0x00200.
- Wrap: redirect_pc=0xFFFFC, memory responds → IF_PC=0xFFFFC, following request addr=0x00000.
- Reset asserted during WAIT, response arrives the cycle after reset → response ignored, request addr=RESET_PC, IF_Valid=0 until the new response arrives.
